instrumented_adder_sequencer: RTL

//  Harness-side controller for the instrumented adder: the driving end of its LA/ring interface.

---
 rtl/instrumented_adder_sequencer_if.sv | 41 ++++
 rtl/instrumented_adder_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_sequencer_if.sv
// Purpose: command, adder-drive and result signals of the instrumented adder
//          sequencer, bundled into one interface.
// Modports:
//   master - the sequencer: takes commands, drives adder operands and ring
//            control, and returns results.
//   slave  - the harness/adder side: issues commands, returns sum and ring
//            count, and consumes results.
interface instrumented_adder_sequencer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned WIN_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [WIN_W-1:0] cmd_window;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_b;
    logic             ring_en;
    logic             cnt_clear;
    logic [WIDTH-1:0] adder_sum;
    logic [CNT_W-1:0] ring_count;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic [CNT_W-1:0] res_count;
    logic [WIN_W-1:0] res_window;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_window, adder_sum, ring_count, res_ready,
        output cmd_ready, adder_a, adder_b, ring_en, cnt_clear,
        output res_valid, res_sum, res_count, res_window
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_window, adder_sum, ring_count, res_ready,
        input  cmd_ready, adder_a, adder_b, ring_en, cnt_clear,
        input  res_valid, res_sum, res_count, res_window
    );
endinterface

// File: rtl/instrumented_adder_sequencer.sv
// Purpose: harness-side controller for the instrumented adder. Accepts a
//          (a, b, window) command, drives and settles the operands, runs the
//          ring oscillator for exactly `window` cycles, drains the count
//          synchroniser, then returns sum/count over a valid/ready handshake.
// Ports:
//   wb_clk_i - clock
//   rst_n    - asynchronous active-low reset
//   active   - project select; low aborts to IDLE
//   bus      - command / adder / result interface (master side)
// Note: SETTLE and DRAIN must both be at least 1.
module instrumented_adder_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned DRAIN  = 3
) (
    input  logic                          wb_clk_i,
    input  logic                          rst_n,
    input  logic                          active,
    instrumented_adder_sequencer_if.master bus
);
    localparam int unsigned PH_MAX = (SETTLE > DRAIN) ? SETTLE : DRAIN;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state_q,     state_d;
    logic [PH_W-1:0]  ph_q,        ph_d;
    logic [WIN_W-1:0] win_q,       win_d;
    logic [WIN_W-1:0] window_q,    window_d;
    logic [WIDTH-1:0] adder_a_q,   adder_a_d;
    logic [WIDTH-1:0] adder_b_q,   adder_b_d;
    logic             ring_en_q,   ring_en_d;
    logic             cnt_clear_q, cnt_clear_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q,   res_sum_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic [WIN_W-1:0] res_win_q,   res_win_d;

    // State and registered outputs; reset clears ring_en without a clock edge.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ph_q        <= '0;
            win_q       <= '0;
            window_q    <= '0;
            adder_a_q   <= '0;
            adder_b_q   <= '0;
            ring_en_q   <= 1'b0;
            cnt_clear_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_count_q <= '0;
            res_win_q   <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            win_q       <= win_d;
            window_q    <= window_d;
            adder_a_q   <= adder_a_d;
            adder_b_q   <= adder_b_d;
            ring_en_q   <= ring_en_d;
            cnt_clear_q <= cnt_clear_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_count_q <= res_count_d;
            res_win_q   <= res_win_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        win_d       = win_q;
        window_d    = window_q;
        adder_a_d   = adder_a_q;
        adder_b_d   = adder_b_q;
        ring_en_d   = ring_en_q;
        cnt_clear_d = 1'b0;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_count_d = res_count_q;
        res_win_d   = res_win_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    adder_a_d   = bus.cmd_a;
                    adder_b_d   = bus.cmd_b;
                    window_d    = bus.cmd_window;
                    win_d       = bus.cmd_window;
                    cnt_clear_d = 1'b1;
                    ph_d        = PH_W'(SETTLE - 1);
                    state_d     = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (ph_q == '0) begin
                    if (win_q != '0) begin
                        ring_en_d = 1'b1;
                        state_d   = S_RUN;
                    end else begin
                        ph_d    = PH_W'(DRAIN - 1);
                        state_d = S_DRAIN;
                    end
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            S_RUN: begin
                // ring_en was raised on entry, so the last enabled cycle is win_q==1.
                win_d = win_q - WIN_W'(1);
                if (win_q == WIN_W'(1)) begin
                    ring_en_d = 1'b0;
                    ph_d      = PH_W'(DRAIN - 1);
                    state_d   = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ph_q == '0) begin
                    res_sum_d   = bus.adder_sum;
                    res_count_d = bus.ring_count;
                    res_win_d   = window_q;
                    res_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    ph_d = ph_q - PH_W'(1);
                end
            end
            S_DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                ring_en_d   = 1'b0;
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        // Deselect aborts everything; operands keep their last values.
        if (!active) begin
            state_d     = S_IDLE;
            ring_en_d   = 1'b0;
            cnt_clear_d = 1'b0;
            res_valid_d = 1'b0;
            adder_a_d   = adder_a_q;
            adder_b_d   = adder_b_q;
            window_d    = window_q;
        end

        cmd_ready_d = active && (state_d == S_IDLE);
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.adder_a    = adder_a_q;
    assign bus.adder_b    = adder_b_q;
    assign bus.ring_en    = ring_en_q;
    assign bus.cnt_clear  = cnt_clear_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_sum    = res_sum_q;
    assign bus.res_count  = res_count_q;
    assign bus.res_window = res_win_q;
endmodule
